sigma_bus_arb: RTL and testbench
================================

# sigma_bus_arb

Round-robin arbiter that shares one slave memory bus port of the sigma SoC (RAM/CSR interconnect) between N requesting masters, nominally UDM debug master, CPU data port and CPU instruction port. It registers one grant at a time, forwards the granted master's request to the slave, routes ack/resp/rdata back, and handles at most one outstanding transaction. A programmable watchdog terminates reads whose response never arrives, so the UDM does not hang on a dead slave.

## Interface
- NUM_M, 3: number of masters (2..8); index 0 is the highest priority after reset.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 1024: read-response watchdog limit in cycles; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: rdata returned on a watchdog timeout.

- clk_i  in  1  system clock; the block uses this single clock.
- rst_i  in  1  reset, synchronous, active-high.
- m_req_i  in  NUM_M  per-master request.
- m_we_i  in  NUM_M  per-master write enable.
- m_addr_i  in  NUM_M*ADDR_W  flattened addresses; master k is at bits [k*ADDR_W +: ADDR_W].
- m_be_i  in  NUM_M*DATA_W/8  flattened byte enables.
- m_wdata_i  in  NUM_M*DATA_W  flattened write data.
- m_ack_o  out  NUM_M  one-hot ack to the granted master.
- m_resp_o  out  NUM_M  one-hot read-response strobe.
- m_rdata_o  out  DATA_W  read data, shared by all masters and qualified by m_resp_o.
- s_req_o, s_we_o  out  1  slave request and write enable.
- s_addr_o  out  ADDR_W; s_be_o  out  DATA_W/8; s_wdata_o  out  DATA_W  slave command fields.
- s_ack_i, s_resp_i  in  1  slave accept and read-data-valid.
- s_rdata_i  in  DATA_W  slave read data.
- err_o  out  1  one-cycle pulse on a watchdog timeout.

## Operation
- FSM states are IDLE, REQ and RESP.
- IDLE
  - Select the first asserted m_req_i, scanning from ptr upward with modulo-NUM_M wrap.
  - On a hit, register grant index g and copy master g's we/addr/be/wdata into the s_* registers.
  - Set s_req_o=1 and go to REQ. With no requests, stay in IDLE.
- REQ
  - s_req_o stays high and the s_* fields stay constant until s_ack_i.
  - m_ack_o[g] = s_ack_i, combinationally, in the same cycle.
  - On ack, s_req_o drops in the next cycle.
  - A write completes: set ptr=(g+1)%NUM_M and go to IDLE.
  - A read goes to RESP, or completes immediately if s_resp_i is high in the ack cycle.
- RESP
  - m_resp_o[g] = s_resp_i and m_rdata_o = s_rdata_i, combinationally.
  - On s_resp_i, set ptr=g+1 (mod NUM_M) and go to IDLE.
- Watchdog
  - A counter clears on entering RESP and increments each cycle in RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 without s_resp_i, the block drives m_resp_o[g]=1, m_rdata_o=ERR_DATA and err_o=1 for one cycle, updates ptr and goes to IDLE.
  - A late s_resp_i arriving in IDLE is ignored.
- Masters hold req and all command fields stable until their ack; the arbiter never re-samples them after the grant.
- Master requirement: a master deasserts m_req_i in the cycle after its ack, or immediately re-requests.
- The rotating pointer guarantees no starvation: worst-case wait is NUM_M-1 transactions.

## Timing
- Reset values:
  - FSM=IDLE, ptr=0, g=0, counter=0.
  - s_req_o=0, s_we_o=0, s_addr_o=0, s_be_o=0, s_wdata_o=0.
  - m_ack_o=0, m_resp_o=0, m_rdata_o=0, err_o=0.
- Grant latency: m_req_i high in cycle N gives s_req_o high in N+1.
- Write turnaround: with 0-wait ack, a write occupies 2 cycles, so a back-to-back next grant is possible with s_req_o high again at N+3.
- Ack/resp path: no register; outside the granted master's slot, all m_ack_o/m_resp_o bits are 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values and no ack/resp issued. A pending slave response is dropped.
- Simultaneous s_ack_i and s_resp_i on a read: both strobes reach master g in the same cycle.
- TIMEOUT_CYCLES=0: RESP waits indefinitely and err_o never asserts.

## Test plan
- Single write: master 1 writes addr 0x0, data 0xDEADBEEF, be 0xF, slave acks in 1 cycle. Required: s_req_o in cycle N+1, m_ack_o=3'b010, FSM back in IDLE, ptr=2.
- Read: master 0 reads 0x80000004, slave acks then responds with 0x00000001 three cycles later. Required: m_resp_o=3'b001 with m_rdata_o=0x00000001 in the same cycle as s_resp_i.
- Fairness: all three masters request continuously with 0-wait writes. Required grant order 0,1,2,0,1,2 and no master waits more than 2 transactions.
- Watchdog: TIMEOUT_CYCLES=16, read acked but never responded. Required: exactly 16 cycles after RESP entry, m_resp_o[g]=1, rdata=0xDEADBEEF, err_o pulses once; a later s_resp_i produces no m_resp_o.
- Reset mid-RESP: assert rst_i for one cycle during a pending read. Required: all outputs 0 next cycle, ptr=0, and master 0 is served first afterwards.
- Hold stability: slave stalls ack for 10 cycles while master 2 toggles m_addr_i. Required: s_addr_o keeps the originally granted value throughout.

Source files
------------

// File: rtl/sigma_bus_arb.sv
// Round-robin arbiter that shares one slave memory port between NUM_M masters,
// with one outstanding transaction and a read-response watchdog.
module sigma_bus_arb #(
  parameter int                NUM_M          = 3,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_M-1:0]           m_req_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr_i,
  input  logic [NUM_M*DATA_W/8-1:0]  m_be_i,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata_i,
  output logic [NUM_M-1:0]           m_ack_o,
  output logic [NUM_M-1:0]           m_resp_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       s_req_o,
  output logic                       s_we_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W/8-1:0]        s_be_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  input  logic                       s_ack_i,
  input  logic                       s_resp_i,
  input  logic [DATA_W-1:0]          s_rdata_i,
  output logic                       err_o
);

  localparam int          BE_W    = DATA_W / 8;
  localparam int          IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               s_req_q, s_req_d;
  logic               s_we_q, s_we_d;
  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [BE_W-1:0]    s_be_q, s_be_d;
  logic [DATA_W-1:0]  s_wdata_q, s_wdata_d;

  logic               hit_s;
  logic [IDX_W-1:0]   pick_s;
  logic               timeout_s;
  logic [NUM_M-1:0]   ack_s, resp_s;
  logic [DATA_W-1:0]  rdata_s;
  logic               err_s;

  logic [ADDR_W-1:0]  addr_a  [NUM_M];
  logic [BE_W-1:0]    be_a    [NUM_M];
  logic [DATA_W-1:0]  wdata_a [NUM_M];

  for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
    assign addr_a[k]  = m_addr_i[k*ADDR_W +: ADDR_W];
    assign be_a[k]    = m_be_i[k*BE_W +: BE_W];
    assign wdata_a[k] = m_wdata_i[k*DATA_W +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(NUM_M - 1)) begin
      return '0;
    end else begin
      return v + IDX_W'(1);
    end
  endfunction

  // Rotating-priority scan: first requester at or after ptr, modulo NUM_M.
  always_comb begin
    logic [IDX_W-1:0] idx_v;
    hit_s  = 1'b0;
    pick_s = '0;
    idx_v  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      idx_v = IDX_W'((int'(ptr_q) + i) % NUM_M);
      if (!hit_s && m_req_i[idx_v]) begin
        hit_s  = 1'b1;
        pick_s = idx_v;
      end else begin
        pick_s = pick_s;
      end
    end
  end

  assign timeout_s = WD_EN && (state_q == ST_RESP) && (cnt_q == TO_LAST) && !s_resp_i;

  // Next-state, pointer update and the unregistered ack/resp return path.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_be_d    = s_be_q;
    s_wdata_d = s_wdata_q;
    ack_s     = '0;
    resp_s    = '0;
    rdata_s   = '0;
    err_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          gnt_d     = pick_s;
          s_req_d   = 1'b1;
          s_we_d    = m_we_i[pick_s];
          s_addr_d  = addr_a[pick_s];
          s_be_d    = be_a[pick_s];
          s_wdata_d = wdata_a[pick_s];
          state_d   = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (s_ack_i) begin
          ack_s[gnt_q] = 1'b1;
          s_req_d      = 1'b0;
          cnt_d        = 32'd0;
          if (s_we_q || s_resp_i) begin
            // Writes and zero-latency reads both finish in the ack cycle.
            resp_s[gnt_q] = !s_we_q;
            rdata_s       = s_we_q ? '0 : s_rdata_i;
            ptr_d         = wrap_inc(gnt_q);
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        cnt_d   = cnt_q + 32'd1;
        rdata_s = s_rdata_i;
        if (s_resp_i || timeout_s) begin
          resp_s[gnt_q] = 1'b1;
          rdata_s       = timeout_s ? ERR_DATA : s_rdata_i;
          err_s         = timeout_s;
          ptr_d         = wrap_inc(gnt_q);
          cnt_d         = 32'd0;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= 32'd0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_be_q    <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_be_q    <= s_be_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign s_req_o   = s_req_q;
  assign s_we_o    = s_we_q;
  assign s_addr_o  = s_addr_q;
  assign s_be_o    = s_be_q;
  assign s_wdata_o = s_wdata_q;
  assign m_ack_o   = ack_s;
  assign m_resp_o  = resp_s;
  assign m_rdata_o = rdata_s;
  assign err_o     = err_s;

endmodule

// File: tb/tb_sigma_bus_arb.sv
// Self-checking bench for sigma_bus_arb: directed scenarios plus randomized traffic,
// checked against a transaction-level round-robin model.
module tb_sigma_bus_arb;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_req, m_we;
  logic [95:0] m_addr, m_wdata;
  logic [11:0] m_be;
  logic [2:0]  m_ack, m_resp;
  logic [31:0] m_rdata;
  logic        s_req, s_we, s_ack, s_resp, err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int we_mode = 0;
  int waits [3];
  int gw;

  sigma_bus_arb #(.NUM_M(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO),
                  .ERR_DATA(32'hDEADBEEF)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester scanning upward from p with wrap.
  function automatic int pick(input logic [2:0] r, input int p);
    for (int j = 0; j < 3; j++) begin
      if (r[(p + j) % 3]) return (p + j) % 3;
    end
    return 0;
  endfunction

  task automatic set_master(input int k);
    m_we[k] = (we_mode == 1) ? 1'b1 : (we_mode == 2) ? 1'b0 : 1'($urandom);
    m_addr[k*32 +: 32]  = $urandom;
    m_wdata[k*32 +: 32] = $urandom;
    m_be[k*4 +: 4]      = 4'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sreq"}, 64'(s_req), 64'd0);
    chk({tag, "_swe_be"}, 64'({s_we, s_be}), 64'd0);
    chk({tag, "_saddr"}, 64'(s_addr), 64'd0);
    chk({tag, "_swdata"}, 64'(s_wdata), 64'd0);
    chk({tag, "_mack"}, 64'(m_ack), 64'd0);
    chk({tag, "_mresp"}, 64'(m_resp), 64'd0);
    chk({tag, "_mrdata"}, 64'(m_rdata), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // One arbitrated transaction, entered and left in an idle cycle.
  // resp_wait: cycles after the ack cycle until s_resp (0 = with ack, <0 = never).
  task automatic txn(input logic [2:0] mask, input int ack_wait, input int resp_wait,
                     input bit toggle, input int rst_at, output int w);
    logic [31:0] ea, ed, rd;
    logic [3:0]  eb;
    logic        ewe;
    logic [2:0]  eack, eresp;
    bit          done, to_now, resp_now;
    int          k;
    for (int i = 0; i < 3; i++) begin
      if (mask[i] && !m_req[i]) begin
        set_master(i);
        m_req[i] = 1'b1;
      end
      if (!m_req[i]) waits[i] = 0;
    end
    s_ack = 1'b0; s_resp = 1'b0;
    #1;
    chk("idle_sreq", 64'(s_req), 64'd0);
    chk("idle_mack", 64'(m_ack), 64'd0);
    w   = pick(m_req, ptr_m);
    ewe = m_we[w]; ea = m_addr[w*32 +: 32]; ed = m_wdata[w*32 +: 32]; eb = m_be[w*4 +: 4];
    for (int i = 0; i < 3; i++) begin
      if (m_req[i] && i != w) begin
        waits[i]++;
        chk("starvation_bound", 64'(waits[i] > 2), 64'd0);
      end
    end
    waits[w] = 0;
    step();
    for (int c = 0; c <= ack_wait; c++) begin
      if (c > 0) step();
      if (toggle) m_addr[w*32 +: 32] = $urandom;
      s_ack   = (c == ack_wait);
      s_resp  = (c == ack_wait) && !ewe && (resp_wait == 0);
      s_rdata = $urandom; rd = s_rdata;
      #1;
      eack  = s_ack  ? 3'(1 << w) : 3'b000;
      eresp = s_resp ? 3'(1 << w) : 3'b000;
      chk("grant_sreq", 64'(s_req), 64'd1);
      chk("grant_saddr", 64'(s_addr), 64'(ea));
      chk("grant_swdata", 64'(s_wdata), 64'(ed));
      chk("grant_swe_be", 64'({s_we, s_be}), 64'({ewe, eb}));
      chk("req_mack", 64'(m_ack), 64'(eack));
      chk("req_mresp", 64'(m_resp), 64'(eresp));
      if (s_resp) chk("req_rdata", 64'(m_rdata), 64'(rd));
    end
    step();
    m_req[w] = 1'b0; s_ack = 1'b0; s_resp = 1'b0;
    if (!ewe && resp_wait != 0) begin
      k = 1; done = 1'b0;
      while (!done) begin
        if (k == rst_at) begin
          rst = 1'b1; m_req = 3'b000;
          step();
          rst = 1'b0; s_resp = 1'b1; s_rdata = $urandom;
          #1;
          check_all_zero("post_rst");
          s_resp = 1'b0; ptr_m = 0;
          for (int i = 0; i < 3; i++) waits[i] = 0;
          return;
        end
        resp_now = (k == resp_wait);
        to_now   = (k == TO) && !resp_now;
        s_resp   = resp_now; s_rdata = $urandom; rd = s_rdata;
        #1;
        eresp = (resp_now || to_now) ? 3'(1 << w) : 3'b000;
        chk("resp_mresp", 64'(m_resp), 64'(eresp));
        chk("resp_err", 64'(err), 64'(to_now));
        chk("resp_sreq", 64'(s_req), 64'd0);
        chk("resp_mack", 64'(m_ack), 64'd0);
        if (resp_now) chk("resp_rdata", 64'(m_rdata), 64'(rd));
        if (to_now)   chk("timeout_rdata", 64'(m_rdata), 64'h0000_0000_DEAD_BEEF);
        done = resp_now || to_now;
        step();
        s_resp = 1'b0;
        k++;
        if (to_now) begin
          s_resp = 1'b1;
          #1;
          chk("late_resp_ignored", 64'(m_resp), 64'd0);
          chk("late_resp_err", 64'(err), 64'd0);
          s_resp = 1'b0;
        end
      end
    end
    ptr_m = (w + 1) % 3;
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    for (int i = 0; i < 3; i++) waits[i] = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    step();

    // Fairness: everyone requests continuously with 0-wait writes.
    we_mode = 1;
    for (int i = 0; i < 6; i++) begin
      txn(3'b111, 0, 0, 1'b0, 0, gw);
      chk("fair_order", 64'(gw), 64'(i % 3));
    end
    m_req = 3'b000;

    // Single write by master 1, then the pointer must favour master 2 over 0.
    m_we[1] = 1'b1; m_addr[32 +: 32] = 32'h0; m_wdata[32 +: 32] = 32'hDEADBEEF;
    m_be[4 +: 4] = 4'hF; m_req[1] = 1'b1;
    txn(3'b010, 0, 0, 1'b0, 0, gw);
    txn(3'b101, 0, 0, 1'b0, 0, gw);
    chk("ptr_after_m1", 64'(gw), 64'd2);
    m_req = 3'b000;

    // Read by master 0 with a delayed response, then a zero-latency read.
    m_we[0] = 1'b0; m_addr[0 +: 32] = 32'h8000_0004; m_be[0 +: 4] = 4'hF; m_req[0] = 1'b1;
    txn(3'b001, 1, 3, 1'b0, 0, gw);
    we_mode = 2;
    txn(3'b010, 0, 0, 1'b0, 0, gw);

    // Hold stability: master 2 stalled for 10 cycles while toggling its address.
    we_mode = 1;
    txn(3'b100, 10, 0, 1'b1, 0, gw);

    // Watchdog: read acked but never answered.
    we_mode = 2;
    txn(3'b010, 0, -1, 1'b0, 0, gw);

    // Reset in the middle of a pending read; master 0 must win afterwards.
    we_mode = 1;
    txn(3'b001, 0, 0, 1'b0, 0, gw);
    we_mode = 2;
    txn(3'b010, 0, -1, 1'b0, 3, gw);
    step();
    we_mode = 1;
    txn(3'b111, 0, 0, 1'b0, 0, gw);
    chk("post_rst_first", 64'(gw), 64'd0);
    m_req = 3'b000;

    // Randomized traffic with carried-over requesters.
    we_mode = 0;
    for (int i = 0; i < 40; i++) begin
      txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 5)), 1'b0, 0, gw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
